// File: rtl/div64_arbiter.sv
// div64_arbiter: round-robin arbiter and sequencer that shares a single
// 64-bit unsigned divider wrapper among NUM_REQ requesters. Divide-by-zero
// is resolved locally. A watchdog aborts divisions that never complete.
module div64_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [64*NUM_REQ-1:0]     req_a,
  input  logic [64*NUM_REQ-1:0]     req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [63:0]               rsp_quotient,
  output logic [63:0]               rsp_remainder,
  output logic                      rsp_dbz,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      div_start,
  output logic [63:0]               div_a,
  output logic [63:0]               div_b,
  input  logic                      div_valid,
  input  logic [63:0]               div_quotient,
  input  logic [63:0]               div_remainder
);

  localparam int DATA_W = 64;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Control and result registers
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [WD_W-1:0]   wd_q;
  logic              dbz_q;
  logic              to_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] rem_q;

  // Per-requester operand views of the packed request buses
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[DATA_W*g +: DATA_W];
    assign b_arr[g] = req_b[DATA_W*g +: DATA_W];
  end

  // Arbitration results
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   sum_w;
  logic [IDX_W-1:0] cand;
  logic             accept;
  logic             win_b_zero;
  logic             timeout_hit;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first pending requester at or above rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum_w     = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum_w = {1'b0, rr_ptr_q} + {1'b0, IDX_W'(off)};
      if (sum_w >= (IDX_W+1)'(NUM_REQ)) begin
        sum_w = sum_w - (IDX_W+1)'(NUM_REQ);
      end
      cand = IDX_W'(sum_w);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // An accept is only possible from IDLE and never while reset is applied
  assign accept      = resetn && (state_q == S_IDLE) && win_found;
  assign win_b_zero  = (b_arr[win_idx] == '0);
  assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a divide result wins over a simultaneous watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = win_b_zero ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (div_valid || timeout_hit) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_dbz     = 1'b0;
    rsp_timeout = 1'b0;
    busy        = (state_q != S_IDLE);
    div_start   = (state_q == S_ISSUE);
    if (accept) begin
      req_ready = onehot(win_idx);
    end
    if (state_q == S_RESP) begin
      rsp_valid   = onehot(grant_q);
      rsp_dbz     = dbz_q;
      rsp_timeout = to_q;
    end
  end

  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign div_a         = a_q;
  assign div_b         = b_q;

  // Operand latch, result capture, watchdog and round-robin pointer update
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wd_q     <= '0;
      dbz_q    <= 1'b0;
      to_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wd_q <= '0;
          if (accept) begin
            a_q     <= a_arr[win_idx];
            b_q     <= b_arr[win_idx];
            grant_q <= win_idx;
            if (win_b_zero) begin
              quot_q <= '1;
              rem_q  <= a_arr[win_idx];
              dbz_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (div_valid) begin
            quot_q <= div_quotient;
            rem_q  <= div_remainder;
          end else if (timeout_hit) begin
            quot_q <= '0;
            rem_q  <= '0;
            to_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_RELEASE: begin
          wd_q <= '0;
        end
        S_RESP: begin
          rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          dbz_q    <= 1'b0;
          to_q     <= 1'b0;
        end
        default: begin
          wd_q <= '0;
        end
      endcase
    end
  end

endmodule
